jpeg_core_decoder: RTL and testbench
====================================

// Module: jpeg_core_decoder
// PURPOSE
// - Receiving end of the JPEG core symbol stream. Consumes one {huff code, len, value} symbol per cycle.
// - Decodes each symbol to (run,size), expands zero runs and applies inverse zigzag.
// - Rebuilds the 64 x 8-bit block in natural order with a valid/ready output handshake.
// - Used as the loopback checker and decode path beside the core encoder.
// PARAMETERS
// - COEF_W  8   coefficient / value width (signed two's complement)
// - CODE_W  16  Huffman code field width (code right-aligned)
// - LEN_W   4   Huffman length field width
// PORTS
// - clk              in   1          single clock, rising edge
// - rst              in   1          asynchronous, active-high reset
// - sym_code         in   CODE_W     Huffman code, LSB-aligned
// - sym_len          in   LEN_W      code length in bits (1..15)
// - sym_val          in   COEF_W     raw coefficient value (0 for EOB/ZRL)
// - sym_valid        in   1          symbol present this cycle (source cannot stall)
// - sym_ready        out  1          decoder accepting; upstream gates start_encoding on it
// - pixel_block_flat out  64*COEF_W  decoded block, natural order, coef k at [k*8 +: 8]
// - block_valid      out  1          block complete, held until accepted
// - block_ready      in   1          downstream accepts block when high with block_valid
// - block_err        out  1          qualifies block_valid: block had a decode error
// - overrun          out  1          1-cycle pulse: sym_valid seen while sym_ready low
// BEHAVIOUR
// - Reset values: all outputs 0 except sym_ready=1. State S_DC, pos=0, block cleared.
// - Reset mid-block: current block discarded, no block_valid.
// - S_DC: first accepted symbol is the DC symbol. Lookup with run forced to 0.
//   - Write coef[0]=sym_val and clear coef[1..63] in the same cycle.
//   - Set pos=1 and go to S_AC.
//   - Key 00 here means DC size 0 (value 0), not EOB.
// - S_AC, per symbol:
//   - key 00 (EOB): go to S_OUT.
//   - key F0 (ZRL): pos += 16.
//   - other keys: write coef[zigzag[pos+run]] = sym_val, then pos += run+1.
// - pos is 7 bits. Sizing rule: any write or ZRL that would leave pos > 64 sets err.
//   - The offending symbol is not written; go to S_DRAIN.
// - S_DRAIN: discard symbols until EOB, then go to S_OUT.
// - Block completes only on EOB. A symbol other than EOB at pos==64 sets err and goes to S_DRAIN.
// - Symbol errors: no table hit for (code,len) sets err and goes to S_DRAIN.
//   - size(sym_val) != decoded size sets err, but the value is still written.
// - Latency: EOB accepted in cycle N gives block_valid=1 in cycle N+1.
// - S_OUT: block_valid=1, block_err=err, sym_ready=0.
//   - pixel_block_flat is stable while block_valid=1.
//   - On block_valid & block_ready: block_valid=0, err=0, sym_ready=1 next cycle, back to S_DC.
//   - Symbols arriving in S_OUT are dropped and raise overrun. Block contents are unaffected.
// - sym_ready is combinational from state: 1 in S_DC/S_AC/S_DRAIN, 0 in S_OUT.
// - Simultaneous EOB and a held block cannot occur: EOB is only accepted when sym_ready=1.
// - Table match is exact on (code, len). Code bits above len must be 0, otherwise no hit.
// STRUCTURE
// - Shared package jpeg_pkg:
//   - ZIGZAG[0:63] table, Huffman code/len table indexed by {run,size}.
//   - KEY_EOB=8'h00, KEY_ZRL=8'hF0, size() function, state encodings.
//   - The encoder uses the same package.
// - Sub-module jpeg_huff_lookup: combinational (code,len) -> {run,size,hit}.
//   - Implemented as a reverse search of the package table.
// - Top level holds the FSM, pos counter, 512-bit block register and error flag.
// TESTING
// - Reset, then DC {011,3,0x05} + EOB {1010,4,0}: block_valid next cycle.
//   - byte0=0x05, other bytes 0, block_err=0.
// - DC {1010,4,0x00} (size 0) + EOB: accepted as DC, not EOB. All-zero block, block_err=0.
// - DC 0x05, {1011,4,0xFF} (run1,size1), EOB: pos 2 -> natural 8.
//   - flat[71:64]=0xFF, block_err=0.
// - DC, ZRL {11111110010,11,0}, {00,2,0x01}: pos 17 -> natural 19.
//   - flat[159:152]=0x01 after EOB, block_err=0.
// - DC, 4x ZRL (pos would exceed 64), EOB: block_valid with block_err=1, no stray writes.
// - Hold block_ready=0 for 3 cycles with sym_valid pulses: sym_ready=0, overrun pulses.
//   - Block unchanged. Then assert rst mid-next-block: block_valid=0, sym_ready=1.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG core definitions: widths, zigzag order, Huffman table and FSM states.
// Used by both the core encoder and the decoder.
package jpeg_pkg;

  localparam int unsigned COEF_W = 8;
  localparam int unsigned CODE_W = 16;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned NCOEF  = 64;
  localparam int unsigned POS_W  = 7;

  localparam logic [7:0] KEY_EOB = 8'h00;
  localparam logic [7:0] KEY_ZRL = 8'hF0;

  typedef enum logic [1:0] {S_DC, S_AC, S_DRAIN, S_OUT} state_t;

  typedef struct packed {
    logic              valid;
    logic [LEN_W-1:0]  len;
    logic [CODE_W-1:0] code;
  } huff_ent_t;

  // Zigzag scan position -> natural (row-major) coefficient index
  localparam logic [5:0] ZIGZAG [NCOEF] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Magnitude category: bits needed for |v|; -128 maps to 8
  function automatic logic [3:0] coef_size(input logic [COEF_W-1:0] v);
    logic [COEF_W:0] mag;
    logic [3:0]      sz;
    mag = v[COEF_W-1] ? -{1'b1, v} : {1'b0, v};
    sz  = 4'd0;
    for (int i = 0; i <= int'(COEF_W); i++) begin
      if (mag[i]) sz = 4'(i + 1);
    end
    return sz;
  endfunction

  // Code for key {run,size}: short codes for common keys, 15-bit escape otherwise
  function automatic huff_ent_t huff_entry(input logic [7:0] key);
    huff_ent_t e;
    e.valid = (key[3:0] != 4'd0) && (key[3:0] <= 4'(COEF_W));
    e.len   = 4'd15;
    e.code  = {1'b0, 7'h7F, key};
    case (key)
      KEY_EOB: e = '{valid: 1'b1, len: 4'd4,  code: 16'h000A};
      8'h01:   e = '{valid: 1'b1, len: 4'd2,  code: 16'h0000};
      8'h02:   e = '{valid: 1'b1, len: 4'd2,  code: 16'h0001};
      8'h03:   e = '{valid: 1'b1, len: 4'd3,  code: 16'h0003};
      8'h11:   e = '{valid: 1'b1, len: 4'd4,  code: 16'h000B};
      KEY_ZRL: e = '{valid: 1'b1, len: 4'd11, code: 16'h07F2};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/jpeg_huff_lookup.sv
// Combinational Huffman decode: exact (code,len) match against the shared table.
module jpeg_huff_lookup
  import jpeg_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  output logic [3:0]        run,
  output logic [3:0]        size,
  output logic              hit
);

  huff_ent_t ent;

  // Reverse search over every {run,size} key; first match wins
  always_comb begin
    run  = 4'd0;
    size = 4'd0;
    hit  = 1'b0;
    ent  = '0;
    for (int k = 0; k < 256; k++) begin
      ent = huff_entry(8'(k));
      if (!hit && ent.valid && ent.code == code && ent.len == len) begin
        hit  = 1'b1;
        run  = 4'(k >> 4);
        size = 4'(k & 15);
      end
    end
  end

endmodule

// File: rtl/jpeg_core_decoder.sv
// Symbol-stream decoder: rebuilds a 64-coefficient block in natural order,
// expanding zero runs and undoing zigzag, with a held valid/ready block output.
module jpeg_core_decoder
  import jpeg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CODE_W-1:0]       sym_code,
  input  logic [LEN_W-1:0]        sym_len,
  input  logic [COEF_W-1:0]       sym_val,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic [NCOEF*COEF_W-1:0] pixel_block_flat,
  output logic                    block_valid,
  input  logic                    block_ready,
  output logic                    block_err,
  output logic                    overrun
);

  state_t           state, state_next;
  logic [POS_W-1:0] pos, pos_next;
  logic             err, err_next;
  logic             clr, wr_en;
  logic [5:0]       wr_idx;
  logic [3:0]       lk_run, lk_size;
  logic             lk_hit;
  logic [7:0]       key, tgt;
  logic             size_bad;

  jpeg_huff_lookup u_lookup (
    .code (sym_code),
    .len  (sym_len),
    .run  (lk_run),
    .size (lk_size),
    .hit  (lk_hit)
  );

  assign key      = {lk_run, lk_size};
  assign tgt      = 8'(pos) + 8'(lk_run);
  assign size_bad = lk_hit && (coef_size(sym_val) != lk_size);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_DC;
    else     state <= state_next;
  end

  // Next state plus block-write / position / error control
  always_comb begin
    state_next = state;
    pos_next   = pos;
    err_next   = err;
    clr        = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = 6'd0;
    unique case (state)
      S_DC: if (sym_valid) begin
        clr = 1'b1;
        if (!lk_hit) begin
          err_next   = 1'b1;
          state_next = S_DRAIN;
        end else begin
          wr_en      = 1'b1;
          pos_next   = 7'd1;
          err_next   = err | size_bad;
          state_next = S_AC;
        end
      end
      S_AC: if (sym_valid) begin
        if (!lk_hit) begin
          err_next   = 1'b1;
          state_next = S_DRAIN;
        end else if (key == KEY_EOB) begin
          err_next   = err | size_bad;
          state_next = S_OUT;
        end else if (key == KEY_ZRL) begin
          if (8'(pos) + 8'd16 > 8'd64) begin
            err_next   = 1'b1;
            state_next = S_DRAIN;
          end else begin
            pos_next = pos + 7'd16;
            err_next = err | size_bad;
          end
        end else if (tgt > 8'd63) begin
          err_next   = 1'b1;
          state_next = S_DRAIN;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = ZIGZAG[tgt[5:0]];
          pos_next = 7'(tgt + 8'd1);
          err_next = err | size_bad;
        end
      end
      S_DRAIN: if (sym_valid && lk_hit && key == KEY_EOB) state_next = S_OUT;
      S_OUT: if (block_ready) begin
        state_next = S_DC;
        err_next   = 1'b0;
        pos_next   = 7'd0;
      end
      default: state_next = S_DC;
    endcase
  end

  always_comb begin
    sym_ready   = 1'b1;
    block_valid = 1'b0;
    block_err   = 1'b0;
    if (state == S_OUT) begin
      sym_ready   = 1'b0;
      block_valid = 1'b1;
      block_err   = err;
    end
  end

  // Block register: DC clears the block, then the addressed byte overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos              <= '0;
      err              <= 1'b0;
      overrun          <= 1'b0;
      pixel_block_flat <= '0;
    end else begin
      pos     <= pos_next;
      err     <= err_next;
      overrun <= sym_valid && !sym_ready;
      if (clr)   pixel_block_flat <= '0;
      if (wr_en) pixel_block_flat[{wr_idx, 3'b000} +: COEF_W] <= sym_val;
    end
  end

endmodule

// File: tb/tb_jpeg_core_decoder.sv
// Bench for jpeg_core_decoder: behavioural block-decode model checked every cycle,
// plus directed blocks with hand-computed byte/err expectations.
module tb_jpeg_core_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  sym_code;
  logic [3:0]   sym_len;
  logic [7:0]   sym_val;
  logic         sym_valid;
  logic         sym_ready;
  logic [511:0] pixel_block_flat;
  logic         block_valid;
  logic         block_ready;
  logic         block_err;
  logic         overrun;

  jpeg_core_decoder dut (
    .clk              (clk),
    .rst              (rst),
    .sym_code         (sym_code),
    .sym_len          (sym_len),
    .sym_val          (sym_val),
    .sym_valid        (sym_valid),
    .sym_ready        (sym_ready),
    .pixel_block_flat (pixel_block_flat),
    .block_valid      (block_valid),
    .block_ready      (block_ready),
    .block_err        (block_err),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int ov_seen = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         zz [64];
  logic [7:0] m_blk [64];
  bit         m_hold, m_err, m_ov;
  int         m_phase;  // 0 expect DC, 1 AC, 2 discarding to EOB
  int         m_pos;

  function automatic int vsize(input logic [7:0] v);
    int m, s;
    m = int'($signed(v));
    if (m < 0) m = -m;
    s = 0;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    return s;
  endfunction

  function automatic void decode(input logic [15:0] c, input logic [3:0] l,
                                 output bit hit, output int run, output int sz);
    hit = 1'b1; run = 0; sz = 0;
    if      (l == 4'd2  && c == 16'h0000) sz = 1;
    else if (l == 4'd2  && c == 16'h0001) sz = 2;
    else if (l == 4'd3  && c == 16'h0003) sz = 3;
    else if (l == 4'd4  && c == 16'h000A) sz = 0;
    else if (l == 4'd4  && c == 16'h000B) begin run = 1; sz = 1; end
    else if (l == 4'd11 && c == 16'h07F2) begin run = 15; sz = 0; end
    else if (l == 4'd15 && c[15:8] == 8'h7F && c[3:0] >= 4'd1 && c[3:0] <= 4'd8 &&
             c[7:0] != 8'h01 && c[7:0] != 8'h02 && c[7:0] != 8'h03 && c[7:0] != 8'h11) begin
      run = int'(c[7:4]);
      sz  = int'(c[3:0]);
    end
    else hit = 1'b0;
  endfunction

  function automatic void model_reset();
    m_hold = 1'b0; m_err = 1'b0; m_ov = 1'b0; m_phase = 0; m_pos = 0;
    for (int i = 0; i < 64; i++) m_blk[i] = 8'h00;
  endfunction

  function automatic logic [511:0] m_flat();
    logic [511:0] f;
    for (int i = 0; i < 64; i++) f[i*8 +: 8] = m_blk[i];
    return f;
  endfunction

  function automatic void model_step();
    bit hit, badsz;
    int run, sz, key;
    m_ov = sym_valid && m_hold;
    if (m_hold) begin
      if (block_ready) begin m_hold = 1'b0; m_err = 1'b0; m_phase = 0; end
      return;
    end
    if (!sym_valid) return;
    decode(sym_code, sym_len, hit, run, sz);
    key   = run * 16 + sz;
    badsz = hit && (vsize(sym_val) != sz);
    if (m_phase == 0) begin
      for (int i = 0; i < 64; i++) m_blk[i] = 8'h00;
      if (!hit) begin m_err = 1'b1; m_phase = 2; end
      else begin m_blk[0] = sym_val; m_pos = 1; m_phase = 1; if (badsz) m_err = 1'b1; end
    end else if (m_phase == 1) begin
      if (!hit) begin m_err = 1'b1; m_phase = 2; end
      else if (key == 0) begin m_hold = 1'b1; if (badsz) m_err = 1'b1; end
      else if (key == 240) begin
        if (m_pos + 16 > 64) begin m_err = 1'b1; m_phase = 2; end
        else begin m_pos += 16; if (badsz) m_err = 1'b1; end
      end else if (m_pos + run > 63) begin m_err = 1'b1; m_phase = 2; end
      else begin
        m_blk[zz[m_pos + run]] = sym_val;
        m_pos += run + 1;
        if (badsz) m_err = 1'b1;
      end
    end else if (hit && key == 0) m_hold = 1'b1;
  endfunction

  // Zigzag order derived by walking anti-diagonals
  initial begin
    int idx;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz[idx] = r * 8 + (s - r); idx++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz[idx] = r * 8 + (s - r); idx++;
        end
      end
    end
  end

  // Per-cycle compare against the model, then advance it with this cycle's inputs
  always @(negedge clk) begin
    if (rst) model_reset();
    chk("sym_ready",   512'(sym_ready),   512'(!m_hold));
    chk("block_valid", 512'(block_valid), 512'(m_hold));
    chk("block_err",   512'(block_err),   512'(m_hold && m_err));
    chk("overrun",     512'(overrun),     512'(m_ov));
    if (m_hold) chk("block", pixel_block_flat, m_flat());
    if (overrun) ov_seen++;
    if (!rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic sym(input logic [15:0] c, input logic [3:0] l, input logic [7:0] v);
    @(posedge clk); #1;
    sym_valid = 1'b1; sym_code = c; sym_len = l; sym_val = v;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    sym_valid = 1'b0; sym_code = '0; sym_len = '0; sym_val = '0;
  endtask

  task automatic wait_block(input string name, input bit exp_err, input int idx,
                            input logic [7:0] exp_byte);
    idle();
    @(negedge clk);
    chk({name, "_latency"}, 512'(block_valid), 512'(1));
    for (int i = 0; i < 8 && !block_valid; i++) @(negedge clk);
    chk({name, "_err"}, 512'(block_err), 512'(exp_err));
    chk({name, "_byte"}, 512'(pixel_block_flat[idx*8 +: 8]), 512'(exp_byte));
  endtask

  task automatic accept();
    @(posedge clk); #1 block_ready = 1'b1;
    @(posedge clk); #1 block_ready = 1'b0;
  endtask

  localparam logic [15:0] C_EOB = 16'h000A;
  localparam logic [15:0] C_ZRL = 16'h07F2;

  initial begin
    rst = 1'b1; sym_valid = 1'b0; sym_code = '0; sym_len = '0; sym_val = '0;
    block_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 512'(sym_ready), 512'(1));
    chk("reset_flat", pixel_block_flat, 512'(0));
    @(posedge clk); #1 rst = 1'b0;

    // DC only
    sym(16'h0003, 4'd3, 8'h05); sym(C_EOB, 4'd4, 8'h00);
    wait_block("dc_only", 1'b0, 0, 8'h05);
    chk("dc_only_rest", 512'(pixel_block_flat[511:8]), 512'(0));
    accept();

    // DC of size 0 uses the EOB code but is not an EOB
    sym(C_EOB, 4'd4, 8'h00); sym(C_EOB, 4'd4, 8'h00);
    wait_block("dc_size0", 1'b0, 0, 8'h00);
    chk("dc_size0_all", pixel_block_flat, 512'(0));
    accept();

    // run 1: zigzag pos 2 -> natural 8
    sym(16'h0003, 4'd3, 8'h05); sym(16'h000B, 4'd4, 8'hFF); sym(C_EOB, 4'd4, 8'h00);
    wait_block("run1", 1'b0, 8, 8'hFF);
    accept();

    // ZRL: pos 17 -> natural 19
    sym(16'h0003, 4'd3, 8'h05); sym(C_ZRL, 4'd11, 8'h00); sym(16'h0000, 4'd2, 8'h01);
    sym(C_EOB, 4'd4, 8'h00);
    wait_block("zrl", 1'b0, 19, 8'h01);
    accept();

    // ZRL overflow
    sym(16'h0003, 4'd3, 8'h05);
    repeat (4) sym(C_ZRL, 4'd11, 8'h00);
    sym(C_EOB, 4'd4, 8'h00);
    wait_block("zrl_ovf", 1'b1, 0, 8'h05);
    chk("zrl_ovf_nostray", 512'(pixel_block_flat[511:8]), 512'(0));
    accept();

    // Fill to pos 64 exactly, then one more coefficient
    sym(16'h0003, 4'd3, 8'h05);
    repeat (3) sym(C_ZRL, 4'd11, 8'h00);
    sym(16'h7FE1, 4'd15, 8'h01);
    sym(16'h0000, 4'd2, 8'h01);
    sym(C_EOB, 4'd4, 8'h00);
    wait_block("pos64", 1'b1, 63, 8'h01);
    accept();

    // Size mismatch: flagged but still written
    sym(16'h0003, 4'd3, 8'h01); sym(C_EOB, 4'd4, 8'h00);
    wait_block("size_bad", 1'b1, 0, 8'h01);
    accept();

    // Table miss (code bits above len) drains to EOB
    sym(16'h0003, 4'd3, 8'h05); sym(16'h0004, 4'd2, 8'h01); sym(16'h0000, 4'd2, 8'h07);
    sym(C_EOB, 4'd4, 8'h00);
    wait_block("miss", 1'b1, 1, 8'h00);
    accept();

    // Escape code, -128 at pos 1, then -3 at pos 2
    sym(16'h0003, 4'd3, 8'h05); sym(16'h7F08, 4'd15, 8'h80); sym(16'h0001, 4'd2, 8'hFD);
    sym(C_EOB, 4'd4, 8'h00);
    wait_block("neg", 1'b0, 1, 8'h80);
    chk("neg_byte8", 512'(pixel_block_flat[71:64]), 512'(8'hFD));

    // Held block: symbols dropped with overrun
    ov_seen = 0;
    sym(16'h0000, 4'd2, 8'h01); idle(); sym(16'h0000, 4'd2, 8'h01); idle();
    @(negedge clk); @(posedge clk); @(negedge clk);
    chk("hold_overruns", 512'(ov_seen), 512'(2));
    chk("hold_valid", 512'(block_valid), 512'(1));
    chk("hold_byte", 512'(pixel_block_flat[15:8]), 512'(8'h80));
    accept();

    // Reset mid-block
    sym(16'h0003, 4'd3, 8'h05); sym(16'h000B, 4'd4, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b1; sym_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 512'(block_valid), 512'(0));
    chk("rst_mid_ready", 512'(sym_ready), 512'(1));
    @(posedge clk); #1 rst = 1'b0;
    sym(16'h0000, 4'd2, 8'h01); sym(C_EOB, 4'd4, 8'h00);
    wait_block("after_rst", 1'b0, 0, 8'h01);
    chk("after_rst_byte8", 512'(pixel_block_flat[71:64]), 512'(0));
    accept();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
